// File: rtl/stopwatch_cntr.sv
// Centisecond stopwatch: prescaled BCD counter (00.00-59.99) with run/pause/lap
// control and a frozen lap display.
module stopwatch_cntr #(
  parameter int unsigned CS_DIV = 1_000_000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [15:0] value,
  output logic        running,
  output logic        lap_active,
  output logic        wrap
);

  localparam int PW = (CS_DIV > 1) ? $clog2(CS_DIV) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(CS_DIV - 1);
  // Per-digit limits, index 0 = cs_ones ... index 3 = s_tens
  localparam logic [3:0][3:0] DIG_MAX = {4'd5, 4'd9, 4'd9, 4'd9};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic [3:0][3:0]  cnt_q, cnt_d;
  logic [15:0]      lap_q, lap_d;
  logic             wrap_q, wrap_d;

  logic counting, tick, carry;
  logic clr_evt, st_evt, lap_evt;

  // Only the highest-priority pulse in a cycle is seen by the FSM
  assign clr_evt = btn_clear;
  assign st_evt  = btn_start & ~btn_clear;
  assign lap_evt = btn_lap & ~btn_start & ~btn_clear;

  assign counting = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick     = counting && (psc_q == PSC_MAX);

  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;
    wrap_d  = 1'b0;
    carry   = tick;

    if (counting) psc_d = tick ? '0 : psc_q + 1'b1;

    // Ripple the tick through the BCD chain; >= also scrubs any illegal digit
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cnt_q[i] >= DIG_MAX[i]) begin
          cnt_d[i] = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
    wrap_d = tick & carry;

    unique case (state_q)
      S_IDLE:  if (st_evt) state_d = S_RUN;
      S_RUN: begin
        if (st_evt) begin
          state_d = S_PAUSE;
        end else if (lap_evt) begin
          state_d = S_LAP;
          lap_d   = cnt_q;
        end
      end
      S_LAP: begin
        if (st_evt)       state_d = S_PAUSE;
        else if (lap_evt) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (clr_evt) begin
          state_d = S_IDLE;
          psc_d   = '0;
          cnt_d   = '0;
          lap_d   = '0;
          wrap_d  = 1'b0;
        end else if (st_evt) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= S_IDLE;
      psc_q   <= '0;
      cnt_q   <= '0;
      lap_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      wrap_q  <= wrap_d;
    end
  end

  assign value      = (state_q == S_LAP) ? lap_q : cnt_q;
  assign running    = counting;
  assign lap_active = (state_q == S_LAP);
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_cntr.sv
// Directed bench for stopwatch_cntr at CS_DIV=4 (one tick every 4 counting cycles).
module tb_stopwatch_cntr;

  logic        clk = 1'b0;
  logic        reset_p, btn_start, btn_lap, btn_clear;
  logic [15:0] value;
  logic        running, lap_active, wrap;

  int checks = 0;
  int failures = 0;

  stopwatch_cntr #(.CS_DIV(4)) dut (
    .clk(clk), .reset_p(reset_p), .btn_start(btn_start), .btn_lap(btn_lap),
    .btn_clear(btn_clear), .value(value), .running(running),
    .lap_active(lap_active), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle pulse on any combination of buttons: {start, lap, clear}
  task automatic pulse(input logic s, input logic l, input logic c);
    btn_start = s; btn_lap = l; btn_clear = c;
    cyc(1);
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
  endtask

  initial begin
    reset_p = 1'b1; btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    cyc(2);
    chk("rst_value", value, 16'h0000);
    chk("rst_running", running, 1'b0);
    chk("rst_lap", lap_active, 1'b0);
    chk("rst_wrap", wrap, 1'b0);
    reset_p = 1'b0;

    // Lap and clear are ignored in IDLE
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    cyc(10);
    chk("idle_value", value, 16'h0000);
    chk("idle_running", running, 1'b0);

    // Basic counting
    pulse(1, 0, 0);
    chk("run_running", running, 1'b1);
    cyc(40);
    chk("run_40", value, 16'h0010);
    cyc(360);
    chk("run_400", value, 16'h0100);
    cyc(92);
    chk("run_0123", value, 16'h0123);

    // Lap freezes the display while counting continues
    pulse(0, 1, 0);
    chk("lap_active", lap_active, 1'b1);
    chk("lap_value", value, 16'h0123);
    cyc(40);
    chk("lap_frozen", value, 16'h0123);
    chk("lap_running", running, 1'b1);
    pulse(0, 1, 0);
    chk("lap_exit_active", lap_active, 1'b0);
    chk("lap_exit_live", value, 16'h0133);

    // Pause with prescaler at 2, then resume without losing the partial tick
    cyc(3);
    chk("pre_pause", value, 16'h0134);
    pulse(1, 0, 0);
    chk("pause_running", running, 1'b0);
    cyc(100);
    chk("pause_hold", value, 16'h0134);
    pulse(1, 0, 0);
    chk("resume_running", running, 1'b1);
    cyc(1);
    chk("resume_1", value, 16'h0134);
    cyc(1);
    chk("resume_2", value, 16'h0135);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    chk("clear_value", value, 16'h0000);
    chk("clear_running", running, 1'b0);

    // Full rollover 59.99 -> 00.00
    pulse(1, 0, 0);
    cyc(23996);
    chk("at_5999", value, 16'h5999);
    chk("no_wrap_yet", wrap, 1'b0);
    cyc(3);
    chk("still_5999", value, 16'h5999);
    cyc(1);
    chk("wrap_value", value, 16'h0000);
    chk("wrap_pulse", wrap, 1'b1);
    cyc(1);
    chk("wrap_one_cycle", wrap, 1'b0);
    pulse(0, 0, 1);
    chk("clear_in_run", running, 1'b1);
    cyc(2);
    chk("after_wrap_count", value, 16'h0001);

    // Start+clear together in PAUSE: clear wins
    pulse(1, 0, 0);
    chk("pause2_running", running, 1'b0);
    pulse(1, 0, 1);
    chk("stclr_value", value, 16'h0000);
    chk("stclr_running", running, 1'b0);

    // Reset in LAP overrides a simultaneous button pulse
    pulse(1, 0, 0);
    cyc(8);
    chk("run2_value", value, 16'h0002);
    pulse(0, 1, 0);
    chk("lap2_active", lap_active, 1'b1);
    cyc(5);
    reset_p = 1'b1; btn_start = 1'b1;
    cyc(1);
    reset_p = 1'b0; btn_start = 1'b0;
    chk("lap_rst_value", value, 16'h0000);
    chk("lap_rst_running", running, 1'b0);
    chk("lap_rst_lap", lap_active, 1'b0);
    chk("lap_rst_wrap", wrap, 1'b0);
    cyc(8);
    chk("post_rst_idle", value, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_cntr.md
STOPWATCH_CNTR -- requirements
Module: stopwatch_cntr

Interface
REQ-001 SHALL have parameter CS_DIV, default 1_000_000, clk cycles per centisecond tick (100 MHz clk -> 100 Hz).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset_p  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port btn_start  input  1  one-cycle start/stop pulse (debounced button rising edge).
REQ-005 SHALL have port btn_lap  input  1  one-cycle lap pulse.
REQ-006 SHALL have port btn_clear  input  1  one-cycle clear pulse.
REQ-007 SHALL have port value  output  16  BCD display word {s_tens, s_ones, cs_tens, cs_ones}, for the 4-digit FND driver.
REQ-008 SHALL have port running  output  1  high in RUN and LAP.
REQ-009 SHALL have port lap_active  output  1  high in LAP.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse on 59.99 -> 00.00 rollover.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, PAUSE, LAP; state register updates on clk edge.
REQ-012 Input priority per cycle SHALL be clear > start > lap; lower-priority pulses in the same cycle are discarded.
REQ-013 IDLE: start -> RUN; lap and clear ignored.
REQ-014 RUN: start -> PAUSE; lap -> LAP, with lap register loaded with the current count in the same edge; clear ignored.
REQ-015 LAP: lap -> RUN; start -> PAUSE; clear ignored.
REQ-016 PAUSE: start -> RUN; clear -> IDLE, zeroing all counters, prescaler and lap register on the same edge; lap ignored.
REQ-017 Prescaler SHALL count 0..CS_DIV-1 only in RUN and LAP, and SHALL hold its value in PAUSE (no tick loss on resume).
REQ-018 A tick SHALL occur on the edge where the prescaler is CS_DIV-1; the prescaler then returns to 0.
REQ-019 On each tick the BCD chain SHALL advance: cs_ones 0-9, carry to cs_tens 0-9, carry to s_ones 0-9, carry to s_tens 0-5.
REQ-020 Rollover from 59.99 SHALL give 00.00 and keep counting; wrap SHALL be high for exactly the cycle after that edge.
REQ-021 No digit SHALL ever hold a value outside its stated range.
REQ-022 value SHALL be driven combinationally from the lap register in LAP, and from the live counters in all other states; zero added latency.
REQ-023 Counting SHALL continue in LAP; on exit from LAP the live count shows immediately.
REQ-024 In the cycle a pulse is accepted, the counters SHALL still advance if a tick is due, unless the pulse is clear.
REQ-025 running and lap_active SHALL be decoded from the state register, with no extra delay.

Reset
REQ-026 reset_p high at a clk edge SHALL force IDLE, prescaler 0, all digits 0, lap register 0 and wrap 0, overriding every button pulse.
REQ-027 After reset: value=16'h0000, running=0, lap_active=0, wrap=0.
REQ-028 reset_p asserted mid-count (RUN/LAP/PAUSE) SHALL have the same effect as REQ-026 on the next edge.

Verification (CS_DIV=4)
REQ-029 Reset 2 cycles -> value=16'h0000, running=0, lap_active=0, wrap=0.
REQ-030 Start pulse, then 40 cycles in RUN -> value=16'h0010, running=1; 400 cycles -> 16'h0100.
REQ-031 RUN to 16'h0123, lap pulse -> lap_active=1 and value frozen at 16'h0123 while counting continues; lap pulse again -> value equals the live count (> 16'h0123).
REQ-032 Start pulse (PAUSE) with prescaler=2 -> 100 idle cycles leave value unchanged; start pulse -> first tick after 2 cycles; clear in PAUSE -> 16'h0000, IDLE.
REQ-033 Run from 0 for 24000 cycles -> at count 16'h5999 the next tick gives 16'h0000, with a one-cycle wrap pulse; clear in RUN has no effect.
REQ-034 Start+clear together in PAUSE -> IDLE with value 0; reset_p pulse in LAP -> IDLE, all outputs zero.
